// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter and sequencer in front of a single-port data memory.
//   Port 0 is the pipeline memory stage, port 1 the debug/program-loader path.
//   One transaction is in flight at a time: accept (IDLE), one-cycle memory
//   command (ISSUE), optional read-latency wait (WAIT), one-cycle response
//   pulse to the winner (RESP).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   per-port request handshake (ready is combinational)
//   req_we            per-port write (1) / read (0)
//   req_addr          per-port byte address, port p at [p*ADDR_W +: ADDR_W]
//   req_wdata, req_be per-port write data and byte enables
//   resp_valid        per-port one-cycle completion pulse
//   resp_rdata        read data, qualified by resp_valid
//   mem_*             single-port memory command / read data
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]     req_wdata,
    input  logic [2*DATA_W/8-1:0]   req_be,
    output logic [1:0]              resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    mem_read_enable,
    output logic                    mem_write_enable,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic [DATA_W/8-1:0]     mem_byte_en,
    input  logic [DATA_W-1:0]       mem_read_data
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY);

    // control state
    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    // latched command payload
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;

    logic              grant_id;

    // Low address bits never reach the memory; word alignment is the
    // requester's concern.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_q[1:0];

    // Round-robin: on a tie the port that did not win last time gets it.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
        req_ready = 2'b00;
        if ((state_q == S_IDLE) && req_valid[grant_id]) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;

        case (state_q)
            S_IDLE: begin
                if (|req_ready) begin
                    grant_d      = grant_id;
                    last_grant_d = grant_id;
                    we_d         = req_we[grant_id];
                    addr_d       = grant_id ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                    wdata_d      = grant_id ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                    be_d         = grant_id ? req_be[BE_W +: BE_W] : req_be[0 +: BE_W];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt==1 marks the cycle RD_LATENCY after ISSUE
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    resp_rdata_d = mem_read_data;
                    state_d      = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= 3'd0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Payload is only observed while in ISSUE, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Memory command is decoded from state so enables can only be high in ISSUE.
    always_comb begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_write_data   = '0;
        mem_byte_en      = '0;
        if (state_q == S_ISSUE) begin
            mem_write_enable = we_q;
            mem_read_enable  = ~we_q;
            mem_addr         = {addr_q[ADDR_W-1:2], 2'b00};
            mem_write_data   = wdata_q;
            mem_byte_en      = we_q ? be_q : '0;
        end
        resp_valid = 2'b00;
        if (state_q == S_RESP) begin
            resp_valid[grant_q] = 1'b1;
        end
    end

    assign resp_rdata = resp_rdata_q;

endmodule
